// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg: shared widths, list depth and FSM state encoding for the k-NN vote block
package knn_vote_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LABEL_W = 8;
  localparam int DEF_K = 4;
  localparam logic [DEF_DATA_W-1:0] INVALID_DIST = '1;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SELECT, DONE} state_t;
endpackage

// File: rtl/knn_vote_if.sv
// knn_vote_if: request, neighbour-list read port and result bundle of the vote block
interface knn_vote_if
  import knn_vote_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int K = DEF_K,
  parameter int data_info = DATA_W + LABEL_W
);
  logic start;
  logic [$clog2(K)-1:0] nb_addr;
  logic nb_rd;
  logic [data_info-1:0] nb_data;
  logic busy;
  logic valid;
  logic [LABEL_W-1:0] label;
  logic [$clog2(K+1)-1:0] votes;
  logic no_vote;
  modport slave(input start, nb_data, output nb_addr, nb_rd, busy, valid, label, votes, no_vote);
  modport master(output start, nb_data, input nb_addr, nb_rd, busy, valid, label, votes, no_vote);
endinterface

// File: rtl/knn_label_tally.sv
// knn_label_tally: K label slots, each counting votes; a repeat label bumps its slot, a new one takes the lowest free slot
module knn_label_tally
  import knn_vote_pkg::*;
#(
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int K = DEF_K
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [LABEL_W-1:0] lbl,
  input  logic [$clog2(K)-1:0] rd_idx,
  output logic [LABEL_W-1:0] rd_label,
  output logic [$clog2(K+1)-1:0] rd_count
);
  localparam int AW = $clog2(K);
  localparam int VW = $clog2(K+1);
  logic [LABEL_W-1:0] labels [K];
  logic [VW-1:0] counts [K];
  logic [K-1:0] used;
  logic hit;
  logic [AW-1:0] hit_idx, free_idx;
  // find the slot already holding this label, and the lowest free slot
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (used[i] && labels[i] == lbl) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
      if (!used[i]) free_idx = AW'(i);
    end
  end
  // bump a matching slot or allocate a fresh one with a single vote
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      used <= '0;
      for (int i = 0; i < K; i++) begin
        labels[i] <= '0;
        counts[i] <= '0;
      end
    end else if (en) begin
      if (hit) counts[hit_idx] <= counts[hit_idx] + 1'b1;
      else begin
        used[free_idx] <= 1'b1;
        labels[free_idx] <= lbl;
        counts[free_idx] <= VW'(1);
      end
    end
  end
  assign rd_label = labels[rd_idx];
  assign rd_count = counts[rd_idx];
endmodule

// File: rtl/knn_vote.sv
// knn_vote: reads the K-entry neighbour list, tallies labels and reports the majority class
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int K = DEF_K,
  parameter int data_info = DATA_W + LABEL_W
) (
  input logic clk,
  input logic rst,
  knn_vote_if.slave bus
);
  localparam int AW = $clog2(K);
  localparam int VW = $clog2(K+1);
  state_t state, nxt;
  logic [AW-1:0] cnt;
  logic last, rd_q, tally_en, take;
  logic [data_info-1:0] entry;
  logic [LABEL_W-1:0] rd_label, best_lbl, pick_lbl;
  logic [VW-1:0] rd_count, best_cnt, pick_cnt;
  assign entry = bus.nb_data;
  assign last = cnt == AW'(K - 1);
  assign tally_en = rd_q && !(&entry[data_info-1 -: DATA_W]);
  knn_label_tally #(.LABEL_W(LABEL_W), .K(K)) tally (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && bus.start),
    .en(tally_en),
    .lbl(entry[LABEL_W-1:0]),
    .rd_idx(cnt),
    .rd_label(rd_label),
    .rd_count(rd_count)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state, read strobe, status and running best-slot comparison
  always_comb begin
    nxt = (state == IDLE && bus.start) ? FETCH :
          (state == FETCH && last) ? DRAIN :
          (state == DRAIN) ? SELECT :
          (state == SELECT && last) ? DONE :
          (state == DONE) ? IDLE : state;
    bus.nb_rd = state == FETCH;
    bus.nb_addr = (state == FETCH) ? cnt : '0;
    bus.busy = state != IDLE;
    bus.valid = state == DONE;
    take = rd_count > best_cnt;
    pick_cnt = take ? rd_count : best_cnt;
    pick_lbl = take ? rd_label : best_lbl;
  end
  // phase counter, read-data qualifier, best-so-far and latched result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rd_q <= 1'b0;
      best_cnt <= '0;
      best_lbl <= '0;
      bus.label <= '0;
      bus.votes <= '0;
      bus.no_vote <= 1'b0;
    end else begin
      cnt <= (state != nxt) ? '0 : cnt + 1'b1;
      rd_q <= bus.nb_rd;
      best_cnt <= (state == SELECT) ? pick_cnt : '0;
      best_lbl <= (state == SELECT) ? pick_lbl : '0;
      if (state == SELECT && last) begin
        bus.label <= pick_lbl;
        bus.votes <= pick_cnt;
        bus.no_vote <= pick_cnt == '0;
      end
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed classification runs with hand-computed votes, reset abort and start re-trigger
module tb_knn_vote;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [39:0] mem [4];
  knn_vote_if #(.DATA_W(32), .LABEL_W(8), .K(4)) bus ();
  knn_vote #(.DATA_W(32), .LABEL_W(8), .K(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.nb_rd) bus.nb_data <= mem[bus.nb_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] lb, input logic [127:0] ds);
    for (int i = 0; i < 4; i++) mem[i] = {ds[32*i +: 32], lb[8*i +: 8]};
  endtask

  task automatic classify(input string tag, input logic [31:0] lb, input logic [127:0] ds,
                          input logic [7:0] el, input logic [2:0] ev, input logic en, input bit retrig);
    int lat, nv, nr;
    logic [7:0] vl;
    logic [2:0] vv;
    logic vn;
    lat = 0; nv = 0; nr = 0; vl = '0; vv = '0; vn = 1'b0;
    load(lb, ds);
    @(negedge clk) bus.start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1 && !retrig) bus.start = 1'b0;
      if (n == 11) bus.start = 1'b0;
      if (n == 1) chk({tag, " busy"}, 64'(bus.busy), 64'd1);
      if (bus.nb_rd) begin
        chk({tag, " nb_addr"}, 64'(bus.nb_addr), 64'(nr));
        nr++;
      end
      if (bus.valid) begin
        nv++;
        if (nv == 1) begin
          lat = n; vl = bus.label; vv = bus.votes; vn = bus.no_vote;
        end
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd10);
    chk({tag, " valid pulses"}, 64'(nv), 64'd1);
    chk({tag, " reads"}, 64'(nr), 64'd4);
    chk({tag, " label"}, 64'(vl), 64'(el));
    chk({tag, " votes"}, 64'(vv), 64'(ev));
    chk({tag, " no_vote"}, 64'(vn), 64'(en));
    chk({tag, " label held"}, 64'(bus.label), 64'(el));
    chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int nv;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst valid", 64'(bus.valid), 64'd0);
    chk("rst nb_rd", 64'(bus.nb_rd), 64'd0);
    chk("rst nb_addr", 64'(bus.nb_addr), 64'd0);
    chk("rst label", 64'(bus.label), 64'd0);
    chk("rst votes", 64'(bus.votes), 64'd0);
    chk("rst no_vote", 64'(bus.no_vote), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    classify("majority", {8'd7, 8'd5, 8'd3, 8'd3}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd3, 3'd2, 1'b0, 1'b0);
    classify("tie nearest", {8'd5, 8'd3, 8'd3, 8'd5}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd5, 3'd2, 1'b0, 1'b0);
    classify("all distinct", {8'd4, 8'd2, 8'd1, 8'd9}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd9, 3'd1, 1'b0, 1'b0);
    classify("two empty", {8'hAA, 8'hAA, 8'd6, 8'd2}, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'd20, 32'd10}, 8'd2, 3'd1, 1'b0, 1'b0);
    classify("all empty", {8'd4, 8'd4, 8'd4, 8'd4}, {4{32'hFFFFFFFF}}, 8'd0, 3'd0, 1'b1, 1'b0);
    classify("unanimous", {8'd7, 8'd7, 8'd7, 8'd7}, {32'd9, 32'd8, 32'd7, 32'd6}, 8'd7, 3'd4, 1'b0, 1'b0);
    classify("retrigger", {8'd7, 8'd5, 8'd3, 8'd3}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd3, 3'd2, 1'b0, 1'b1);
    load({8'd7, 8'd5, 8'd3, 8'd3}, {32'd4, 32'd3, 32'd2, 32'd1});
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort nb_rd", 64'(bus.nb_rd), 64'd0);
    rst = 1'b0;
    nv = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    chk("abort valid pulses", 64'(nv), 64'd0);
    classify("after abort", {8'd5, 8'd3, 8'd3, 8'd5}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'd5, 3'd2, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
